// File: rtl/ex_stage.sv
// Execute stage: integer ALU and shifter, HI/LO register pair, multiplier and a
// restoring divider that stalls the upstream pipeline while it iterates.
module ex_stage #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  aluop,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [4:0]  wd,
    input  logic        wreg,
    input  logic        flush,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_NOR   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLTU  = 5'd8;
    localparam logic [4:0] OP_SLL   = 5'd9;
    localparam logic [4:0] OP_SRL   = 5'd10;
    localparam logic [4:0] OP_SRA   = 5'd11;
    localparam logic [4:0] OP_MULT  = 5'd12;
    localparam logic [4:0] OP_MULTU = 5'd13;
    localparam logic [4:0] OP_DIV   = 5'd14;
    localparam logic [4:0] OP_DIVU  = 5'd15;
    localparam logic [4:0] OP_MFHI  = 5'd16;
    localparam logic [4:0] OP_MFLO  = 5'd17;
    localparam logic [4:0] OP_MTHI  = 5'd18;
    localparam logic [4:0] OP_MTLO  = 5'd19;

    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t       state;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      dvd;
    logic [31:0]      dvs;
    logic [31:0]      rem;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;

    logic        is_div;
    logic        signed_div;
    logic        div_start;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [32:0] rem_shift;
    logic        fits;
    logic [31:0] rem_sub;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] result;
    logic        writes_gpr;
    logic [4:0]  shamt;

    assign is_div     = (aluop == OP_DIV) || (aluop == OP_DIVU);
    assign signed_div = (aluop == OP_DIV);
    assign div_start  = (state == IDLE) && is_div && (src2 != 32'd0);
    assign stall_req  = (div_start && !flush) || (state == BUSY);

    assign abs1 = (signed_div && src1[31]) ? (32'd0 - src1) : src1;
    assign abs2 = (signed_div && src2[31]) ? (32'd0 - src2) : src2;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
    assign prod_u = {32'd0, src1} * {32'd0, src2};

    // Restoring step: dvd shifts out dividend bits and shifts in quotient bits.
    assign rem_shift = {rem, dvd[31]};
    assign fits      = rem_shift >= {1'b0, dvs};
    assign rem_sub   = rem_shift[31:0] - dvs;
    assign quot_fix  = neg_q ? (32'd0 - dvd) : dvd;
    assign rem_fix   = neg_r ? (32'd0 - rem) : rem;

    assign shamt = src1[4:0];

    always_comb begin
        result     = 32'd0;
        writes_gpr = 1'b0;
        case (aluop)
            OP_ADD:  begin result = src1 + src2;                       writes_gpr = 1'b1; end
            OP_SUB:  begin result = src1 - src2;                       writes_gpr = 1'b1; end
            OP_AND:  begin result = src1 & src2;                       writes_gpr = 1'b1; end
            OP_OR:   begin result = src1 | src2;                       writes_gpr = 1'b1; end
            OP_XOR:  begin result = src1 ^ src2;                       writes_gpr = 1'b1; end
            OP_NOR:  begin result = ~(src1 | src2);                    writes_gpr = 1'b1; end
            OP_SLT:  begin result = {31'd0, $signed(src1) < $signed(src2)}; writes_gpr = 1'b1; end
            OP_SLTU: begin result = {31'd0, src1 < src2};              writes_gpr = 1'b1; end
            OP_SLL:  begin result = src2 << shamt;                     writes_gpr = 1'b1; end
            OP_SRL:  begin result = src2 >> shamt;                     writes_gpr = 1'b1; end
            OP_SRA:  begin result = $unsigned($signed(src2) >>> shamt); writes_gpr = 1'b1; end
            OP_MFHI: begin result = hi;                                writes_gpr = 1'b1; end
            OP_MFLO: begin result = lo;                                writes_gpr = 1'b1; end
            default: begin result = 32'd0;                             writes_gpr = 1'b0; end
        endcase
    end

    assign wd_o    = wd;
    assign wdata_o = result;
    assign wreg_o  = wreg && writes_gpr && !stall_req && !flush;
    assign hi_o    = hi;
    assign lo_o    = lo;

    // Flush discards any division in progress and blocks every HI/LO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi    <= 32'd0;
            lo    <= 32'd0;
            dvd   <= 32'd0;
            dvs   <= 32'd0;
            rem   <= 32'd0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        dvd   <= abs1;
                        dvs   <= abs2;
                        rem   <= 32'd0;
                        cnt   <= '0;
                        neg_q <= signed_div && (src1[31] ^ src2[31]);
                        neg_r <= signed_div && src1[31];
                        state <= BUSY;
                    end else if (aluop == OP_MULT) begin
                        hi <= prod_s[63:32];
                        lo <= prod_s[31:0];
                    end else if (aluop == OP_MULTU) begin
                        hi <= prod_u[63:32];
                        lo <= prod_u[31:0];
                    end else if (aluop == OP_MTHI) begin
                        hi <= src1;
                    end else if (aluop == OP_MTLO) begin
                        lo <= src1;
                    end
                end
                BUSY: begin
                    rem <= fits ? rem_sub : rem_shift[31:0];
                    dvd <= {dvd[30:0], fits};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    lo    <= quot_fix;
                    hi    <= rem_fix;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference
// model of the ALU results and the HI/LO register pair.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  aluop;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  wd;
    logic        wreg;
    logic        flush;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int fails  = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    always #5 clk = ~clk;

    ex_stage #(.DIV_ITERS(32)) dut (
        .clk(clk), .rst(rst), .aluop(aluop), .src1(src1), .src2(src2),
        .wd(wd), .wreg(wreg), .flush(flush), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stall_req(stall_req), .hi_o(hi_o), .lo_o(lo_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic bit refWrites(input logic [4:0] op);
        return (op >= 5'd1 && op <= 5'd11) || op == 5'd16 || op == 5'd17;
    endfunction

    function automatic logic [31:0] refResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        case (op)
            5'd1:  return a + b;
            5'd2:  return a - b;
            5'd3:  return a & b;
            5'd4:  return a | b;
            5'd5:  return a ^ b;
            5'd6:  return ~(a | b);
            5'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'd8:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            5'd9:  return b << sh;
            5'd10: return b >> sh;
            5'd11: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            5'd16: return hi_m;
            5'd17: return lo_m;
            default: return 32'd0;
        endcase
    endfunction

    // One non-divide instruction: combinational checks, then HI/LO after the edge.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic w, input logic f);
        longint p;
        longint unsigned pu;
        aluop = op; src1 = a; src2 = b; wreg = w; flush = f; wd = 5'($urandom());
        #2;
        if (refWrites(op)) checkOutput($sformatf("wdata op%0d", op), wdata_o, refResult(op, a, b));
        checkOutput($sformatf("wreg_o op%0d", op), {31'd0, wreg_o}, {31'd0, w && refWrites(op) && !f});
        checkOutput("stall idle", {31'd0, stall_req}, 32'd0);
        checkOutput("wd_o", {27'd0, wd_o}, {27'd0, wd});
        @(posedge clk); #1;
        if (!f) begin
            if (op == 5'd12) begin
                p = longint'(int'(a)) * longint'(int'(b));
                hi_m = p[63:32]; lo_m = p[31:0];
            end else if (op == 5'd13) begin
                pu = longint'(a) * longint'(b);
                hi_m = pu[63:32]; lo_m = pu[31:0];
            end else if (op == 5'd18) begin
                hi_m = a;
            end else if (op == 5'd19) begin
                lo_m = a;
            end
        end
        checkOutput($sformatf("hi after op%0d", op), hi_o, hi_m);
        checkOutput($sformatf("lo after op%0d", op), lo_o, lo_m);
    endtask

    // Full division: counts stall cycles, then checks HI/LO around the DONE edge.
    task automatic doDiv(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int cnt;
        longint q;
        longint r;
        aluop = op; src1 = a; src2 = b; wreg = 1'b1; flush = 1'b0; wd = 5'd3;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (!stall_req) break;
            cnt++;
            @(posedge clk); #1;
        end
        checkOutput($sformatf("div stall cycles %h/%h", a, b), cnt, (b != 0) ? 32'd33 : 32'd0);
        checkOutput("div wreg_o", {31'd0, wreg_o}, 32'd0);
        checkOutput("div hi before write", hi_o, hi_m);
        checkOutput("div lo before write", lo_o, lo_m);
        @(posedge clk); #1;
        if (b != 0) begin
            if (op == 5'd14) begin
                q = longint'(int'(a)) / longint'(int'(b));
                r = longint'(int'(a)) % longint'(int'(b));
            end else begin
                q = longint'(a) / longint'(b);
                r = longint'(a) % longint'(b);
            end
            lo_m = q[31:0]; hi_m = r[31:0];
        end
        checkOutput($sformatf("div lo %h/%h", a, b), lo_o, lo_m);
        checkOutput($sformatf("div hi %h/%h", a, b), hi_o, hi_m);
    endtask

    initial begin
        logic [4:0] op;
        rst = 1'b1; aluop = 5'd0; src1 = 32'd0; src2 = 32'd0; wd = 5'd0; wreg = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        checkOutput("reset stall", {31'd0, stall_req}, 32'd0);
        checkOutput("reset wreg_o", {31'd0, wreg_o}, 32'd0);
        checkOutput("reset hi", hi_o, 32'd0);
        checkOutput("reset lo", lo_o, 32'd0);
        @(posedge clk); #1;

        applyStimulus(5'd1, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
        applyStimulus(5'd11, 32'd4, 32'h8000_0000, 1'b1, 1'b0);
        applyStimulus(5'd8, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        applyStimulus(5'd12, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        applyStimulus(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        doDiv(5'd14, 32'hFFFF_FFF9, 32'd2);
        doDiv(5'd15, 32'd100, 32'd7);
        applyStimulus(5'd18, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        applyStimulus(5'd19, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
        doDiv(5'd14, 32'd55, 32'd0);
        applyStimulus(5'd16, 32'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(5'd17, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush in BUSY cycle 10 abandons the division.
        aluop = 5'd14; src1 = 32'd100; src2 = 32'd7; flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #2;
        checkOutput("stall in busy", {31'd0, stall_req}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; aluop = 5'd0;
        #2;
        checkOutput("stall after flush", {31'd0, stall_req}, 32'd0);
        checkOutput("hi after flush", hi_o, hi_m);
        checkOutput("lo after flush", lo_o, lo_m);
        @(posedge clk); #1;
        applyStimulus(5'd19, 32'd5, 32'd0, 1'b0, 1'b0);

        // Reset in the middle of a division.
        aluop = 5'd15; src1 = 32'd1000; src2 = 32'd3;
        for (int i = 0; i < 5; i++) begin
            #2;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; aluop = 5'd0;
        hi_m = 32'd0; lo_m = 32'd0;
        #2;
        checkOutput("stall after reset", {31'd0, stall_req}, 32'd0);
        checkOutput("hi after reset", hi_o, 32'd0);
        checkOutput("lo after reset", lo_o, 32'd0);
        @(posedge clk); #1;
        doDiv(5'd15, 32'd9, 32'd3);

        for (int i = 0; i < 300; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd14 || op == 5'd15) op = 5'd0;
            applyStimulus(op, pickVal(), pickVal(), 1'($urandom()), ($urandom_range(0, 7) == 0));
        end

        // Back-to-back divisions with no idle gap, some by zero.
        for (int i = 0; i < 8; i++) begin
            doDiv($urandom_range(0, 1) ? 5'd14 : 5'd15, pickVal(),
                  ($urandom_range(0, 4) == 0) ? 32'd0 : pickVal());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
